// File: rtl/gemv_mac_stream.sv
// Streaming signed dot product: LANES products per beat, BEATS beats per result; SATURATE_EN selects clamping accumulation.
// Latency: last beat accepted in cycle t -> out_valid in cycle t+3.
// Backpressure: in_ready drops after the final beat until the result is taken; result holds while out_ready is low.
module gemv_mac_stream #(
    parameter int DW    = 16,
    parameter int LANES = 8,
    parameter int BEATS = 4,
    parameter int ACCW  = 40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   vec_in,
    input  logic [LANES*DW-1:0]   mat_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACCW-1:0]       result,
    output logic                  sat_flag
);

    localparam int PW = 2 * DW;
    localparam int SW = PW + $clog2(LANES);
`ifdef SATURATE_EN
    localparam int S2W = (ACCW > SW) ? ACCW : SW;
`else
    localparam int S2W = ACCW;
`endif
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {ACC, FLUSH, OUT} state_t;

    state_t            state;
    logic [CW-1:0]     beat_cnt;
    logic              first_pend;
    logic              xfer;
    logic              last_beat;
    logic              hs;

    assign xfer      = in_valid & in_ready;
    assign last_beat = (beat_cnt == CW'(BEATS - 1));
    assign hs        = out_valid & out_ready;

    logic signed [PW-1:0]  prod_q [LANES];
    logic                  s1_vld, s1_first, s1_last;
    logic signed [S2W-1:0] tree_sum;
    logic signed [S2W-1:0] s2_sum;
    logic                  s2_vld, s2_first, s2_last;
    logic signed [ACCW-1:0] acc_q;
    logic [ACCW-1:0]       acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_vld <= xfer;
            if (xfer) begin
                s1_first <= first_pend;
                s1_last  <= last_beat;
                for (int i = 0; i < LANES; i++) begin
                    prod_q[i] <= PW'($signed(vec_in[i*DW +: DW])) * PW'($signed(mat_in[i*DW +: DW]));
                end
            end
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum = tree_sum + S2W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_vld   <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_sum   <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_first <= s1_first;
                s2_last  <= s1_last;
                s2_sum   <= tree_sum;
            end
        end
    end

`ifdef SATURATE_EN
    // One guard bit above the wider of accumulator and beat sum exposes overflow.
    localparam logic signed [S2W:0] MAX_V = {{(S2W+2-ACCW){1'b0}}, {(ACCW-1){1'b1}}};
    localparam logic signed [S2W:0] MIN_V = {{(S2W+2-ACCW){1'b1}}, {(ACCW-1){1'b0}}};
    logic signed [S2W:0] acc_sum;
    logic                ovf;
    logic                sat_q;

    always_comb begin
        acc_sum  = (s2_first ? '0 : (S2W+1)'(acc_q)) + (S2W+1)'(s2_sum);
        acc_next = acc_sum[ACCW-1:0];
        ovf      = 1'b0;
        if (acc_sum > MAX_V) begin
            acc_next = {1'b0, {(ACCW-1){1'b1}}};
            ovf      = 1'b1;
        end else if (acc_sum < MIN_V) begin
            acc_next = {1'b1, {(ACCW-1){1'b0}}};
            ovf      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            sat_q <= 1'b0;
        else if (hs)
            sat_q <= 1'b0;
        else if (s2_vld && ovf)
            sat_q <= 1'b1;
    end

    assign sat_flag = sat_q;
`else
    always_comb begin
        acc_next = (s2_first ? '0 : acc_q) + s2_sum;
    end

    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            acc_q <= '0;
        else if (hs)
            acc_q <= '0;
        else if (s2_vld)
            acc_q <= acc_next;
    end

    assign result = acc_q;

    // The last beat reaches the accumulator on the same edge that raises out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ACC;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            beat_cnt   <= '0;
            first_pend <= 1'b1;
        end else begin
            case (state)
                ACC: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        first_pend <= 1'b0;
                        if (last_beat) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    in_ready <= 1'b0;
                    if (s2_vld && s2_last) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state      <= ACC;
                        out_valid  <= 1'b0;
                        in_ready   <= 1'b1;
                        beat_cnt   <= '0;
                        first_pend <= 1'b1;
                    end
                end
                default: begin
                    state    <= ACC;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gemv_mac_stream.sv
// Randomised bench for gemv_mac_stream: a 40-bit and a 34-bit instance run in lockstep against an arithmetic model.
module tb_gemv_mac_stream;

    localparam int DW    = 16;
    localparam int LANES = 8;
    localparam int BEATS = 4;
`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic [LANES*DW-1:0] vec_in = '0;
    logic [LANES*DW-1:0] mat_in = '0;

    logic                in_ready, out_valid, sat_flag;
    logic [39:0]         result;
    logic                in_ready34, out_valid34, sat_flag34;
    logic [33:0]         result34;

    int     n_cmp = 0;
    int     n_err = 0;
    longint sums[$];

    always #5 clk = ~clk;

    gemv_mac_stream #(.DW(DW), .LANES(LANES), .BEATS(BEATS), .ACCW(40)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .vec_in(vec_in), .mat_in(mat_in), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .sat_flag(sat_flag)
    );

    gemv_mac_stream #(.DW(DW), .LANES(LANES), .BEATS(BEATS), .ACCW(34)) u_dut34 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready34),
        .vec_in(vec_in), .mat_in(mat_in), .out_valid(out_valid34), .out_ready(out_ready),
        .result(result34), .sat_flag(sat_flag34)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint lane_sum(input logic [LANES*DW-1:0] v, input logic [LANES*DW-1:0] m);
        longint s = 0;
        for (int i = 0; i < LANES; i++)
            s += longint'($signed(v[i*DW +: DW])) * longint'($signed(m[i*DW +: DW]));
        return s;
    endfunction

    // Expected result of the queued beats for a w-bit accumulator, clamping or wrapping.
    function automatic longint dot_ref(input int w, input bit sat, output bit flag);
        longint acc = 0;
        longint mx  = (64'sd1 <<< (w - 1)) - 1;
        longint mn  = -(64'sd1 <<< (w - 1));
        flag = 1'b0;
        foreach (sums[i]) begin
            acc = acc + sums[i];
            if (sat) begin
                if (acc > mx) begin acc = mx; flag = 1'b1; end
                if (acc < mn) begin acc = mn; flag = 1'b1; end
            end else begin
                acc = (acc <<< (64 - w)) >>> (64 - w);
            end
        end
        return acc;
    endfunction

    function automatic logic [LANES*DW-1:0] fill(input logic [DW-1:0] x);
        return {LANES{x}};
    endfunction

    task automatic send_beat(input logic [LANES*DW-1:0] v, input logic [LANES*DW-1:0] m);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        vec_in   = v;
        mat_in   = m;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("beat_accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sums.push_back(lane_sum(v, m));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        vec_in   = {4{$urandom}};
        mat_in   = {4{$urandom}};
    endtask

    task automatic collect(input int hold);
        int     n = 1;
        bit     f40, f34;
        longint e40, e34;
        @(negedge clk);
        in_valid = 1'b0;
        check("flush_in_ready", in_ready, 0);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("out_latency", n, 3);
        if (!out_valid) begin
            sums.delete();
            return;
        end
        e40 = dot_ref(40, SAT, f40);
        e34 = dot_ref(34, SAT, f34);
        check("result40", longint'($signed(result)), e40);
        check("result34", longint'($signed(result34)), e34);
        check("sat40", sat_flag, f40);
        check("sat34", sat_flag34, f34);
        check("out_in_ready", in_ready, 0);
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            vec_in    = {4{$urandom}};
            mat_in    = {4{$urandom}};
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", longint'($signed(result)), e40);
            check("hold_in_ready", in_ready, 0);
            check("hold_sat34", sat_flag34, f34);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_hs_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_sat34", sat_flag34, 0);
        sums.delete();
    endtask

    task automatic rand_dot();
        logic [LANES*DW-1:0] v, m;
        for (int b = 0; b < BEATS; b++) begin
            for (int i = 0; i < LANES; i++) begin
                v[i*DW +: DW] = DW'($urandom);
                m[i*DW +: DW] = DW'($urandom);
            end
            if ($urandom_range(0, 3) == 0) idle();
            send_beat(v, m);
        end
        collect($urandom_range(0, 3));
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", longint'(result), 0);
        check("rst_sat", sat_flag, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_in_ready", in_ready, 1);

        out_ready = 1'b1;
        for (int b = 0; b < BEATS; b++) send_beat(fill(16'sd1), fill(16'sd1));
        collect(0);

        out_ready = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            if (b != 0) idle();
            send_beat(fill(-16'sd3), fill(16'sd7));
        end
        collect(0);

        for (int b = 0; b < BEATS; b++) send_beat(fill(16'h8000), fill(16'h8000));
        collect(5);

        for (int b = 0; b < BEATS; b++) send_beat(fill(16'sd2), fill(16'sd2));
        collect(0);

        out_ready = 1'b0;
        for (int b = 0; b < 2; b++) send_beat(fill(16'sd1), fill(16'sd1));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", longint'(result), 0);
        check("midrst_result34", longint'(result34), 0);
        check("midrst_in_ready", in_ready, 0);
        sums.delete();
        for (int b = 0; b < BEATS; b++) send_beat(fill(16'sd1), fill(16'sd1));
        collect(0);

        for (int r = 0; r < 8; r++) begin
            out_ready = $urandom_range(0, 1) == 1;
            rand_dot();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
